// File: rtl/m_stage.sv
// Memory stage of a 5-stage MIPS-style pipeline: byte-addressable data memory,
// load extension, alignment checks and the M->W pipeline registers.
module m_stage #(
  parameter int DM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRM,
  input  logic [31:0] PC4M,
  input  logic [31:0] AOM,
  input  logic [31:0] RTM,
  input  logic        Forward_RT_M_Sel,
  input  logic [31:0] MUX_RF_WD_OUT,
  output logic [31:0] IRW,
  output logic [31:0] PC4W,
  output logic [31:0] AOW,
  output logic [31:0] DRW,
  output logic        AdELW,
  output logic        AdESW,
  output logic [31:0] AO
);

  localparam int AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0] s;
    s = $signed(b);
    return sgn ? 32'(s) : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] s;
    s = $signed(h);
    return sgn ? 32'(s) : {16'b0, h};
  endfunction

  logic [31:0]   mem_q [DM_WORDS];
  logic [31:0]   irw_q, pc4w_q, aow_q, drw_q;
  logic          adel_q, ades_q;
  logic [31:0]   drw_d;
  logic          adel_d, ades_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [AW-1:0] idx;
  logic [5:0]    op;
  logic [31:0]   sd;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  assign op      = IRM[31:26];
  assign idx     = AOM[AW+1:2];
  assign sd      = Forward_RT_M_Sel ? MUX_RF_WD_OUT : RTM;
  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[{AOM[1:0], 3'b000} +: 8];
  assign rd_half = AOM[1] ? rd_word[31:16] : rd_word[15:0];
  assign AO      = AOM;

  // Store decode: misaligned stores produce an all-zero byte enable.
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = sd;
    ades_d  = 1'b0;
    case (op)
      OP_SW: begin
        ades_d = (AOM[1:0] != 2'b00);
        be_d   = ades_d ? 4'b0000 : 4'b1111;
      end
      OP_SH: begin
        ades_d  = AOM[0];
        wdata_d = {2{sd[15:0]}};
        be_d    = ades_d ? 4'b0000 : (AOM[1] ? 4'b1100 : 4'b0011);
      end
      OP_SB: begin
        wdata_d = {4{sd[7:0]}};
        be_d    = 4'b0001 << AOM[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    drw_d  = 32'h0;
    adel_d = 1'b0;
    case (op)
      OP_LW: begin
        adel_d = (AOM[1:0] != 2'b00);
        drw_d  = adel_d ? 32'h0 : rd_word;
      end
      OP_LB:  drw_d = ext8(rd_byte, 1'b1);
      OP_LBU: drw_d = ext8(rd_byte, 1'b0);
      OP_LH: begin
        adel_d = AOM[0];
        drw_d  = adel_d ? 32'h0 : ext16(rd_half, 1'b1);
      end
      OP_LHU: begin
        adel_d = AOM[0];
        drw_d  = adel_d ? 32'h0 : ext16(rd_half, 1'b0);
      end
      default: ;
    endcase
  end

  // Data memory: whole array clears while reset is held low.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int w = 0; w < DM_WORDS; w++) mem_q[w] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (be_d[b]) mem_q[idx][8*b +: 8] <= wdata_d[8*b +: 8];
    end
  end

  // M -> W pipeline boundary.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      irw_q  <= 32'h0;
      pc4w_q <= 32'h0;
      aow_q  <= 32'h0;
      drw_q  <= 32'h0;
      adel_q <= 1'b0;
      ades_q <= 1'b0;
    end else begin
      irw_q  <= IRM;
      pc4w_q <= PC4M;
      aow_q  <= AOM;
      drw_q  <= drw_d;
      adel_q <= adel_d;
      ades_q <= ades_d;
    end
  end

  assign IRW   = irw_q;
  assign PC4W  = pc4w_q;
  assign AOW   = aow_q;
  assign DRW   = drw_q;
  assign AdELW = adel_q;
  assign AdESW = ades_q;

endmodule

// File: tb/tb_m_stage.sv
// Scoreboard bench for m_stage: each issued instruction queues its expected
// W-stage outputs, which a negedge monitor compares one cycle later.
module tb_m_stage;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] IRM = 32'h0, PC4M = 32'h0, AOM = 32'h0, RTM = 32'h0;
  logic        Forward_RT_M_Sel = 1'b0;
  logic [31:0] MUX_RF_WD_OUT = 32'h0;
  logic [31:0] IRW, PC4W, AOW, DRW, AO;
  logic        AdELW, AdESW;

  m_stage #(.DM_WORDS(1024)) dut (
    .Clk(Clk), .Reset(Reset), .IRM(IRM), .PC4M(PC4M), .AOM(AOM), .RTM(RTM),
    .Forward_RT_M_Sel(Forward_RT_M_Sel), .MUX_RF_WD_OUT(MUX_RF_WD_OUT),
    .IRW(IRW), .PC4W(PC4W), .AOW(AOW), .DRW(DRW), .AdELW(AdELW),
    .AdESW(AdESW), .AO(AO)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    logic [31:0] ir, pc4, ao, drw;
    logic        adel, ades;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] pc4_v = 32'h0;
  logic [31:0] mdl [1024];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Reset) begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        mon_e = sb_q.pop_front();
        total_cnt++;
        if (mon_e.due != cyc || IRW !== mon_e.ir || PC4W !== mon_e.pc4 ||
            AOW !== mon_e.ao || DRW !== mon_e.drw || AdELW !== mon_e.adel ||
            AdESW !== mon_e.ades)
          $display("FAIL wstage cyc=%0d got IRW=%h PC4W=%h AOW=%h DRW=%h AdEL=%b AdES=%b want IRW=%h PC4W=%h AOW=%h DRW=%h AdEL=%b AdES=%b due=%0d",
                   cyc, IRW, PC4W, AOW, DRW, AdELW, AdESW, mon_e.ir, mon_e.pc4,
                   mon_e.ao, mon_e.drw, mon_e.adel, mon_e.ades, mon_e.due);
        else
          pass_cnt++;
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] ao,
                       input logic [31:0] rt, input logic fwd,
                       input logic [31:0] wd, input logic [31:0] edrw,
                       input logic eadel, input logic eades);
    exp_t e;
    @(posedge Clk);
    #2;
    pc4_v = pc4_v + 32'd4;
    IRM = (op == 6'b0) ? 32'h0 : {op, 5'd3, 5'd4, pc4_v[15:0]};
    PC4M = pc4_v;
    AOM = ao;
    RTM = rt;
    Forward_RT_M_Sel = fwd;
    MUX_RF_WD_OUT = wd;
    e.due = cyc + 1;
    e.ir = IRM;
    e.pc4 = pc4_v;
    e.ao = ao;
    e.drw = edrw;
    e.adel = eadel;
    e.ades = eades;
    sb_q.push_back(e);
  endtask

  task automatic go_idle();
    @(posedge Clk);
    #2;
    IRM = 32'h0;
    AOM = 32'h0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    IRM = {OP_SW, 26'h0};
    PC4M = 32'h1234;
    AOM = 32'h10;
    RTM = 32'hFFFF_FFFF;
    repeat (2) @(posedge Clk);
    #1;
    total_cnt++;
    if ({IRW, PC4W, AOW, DRW, AdELW, AdESW} !== 130'h0)
      $display("FAIL reset_outputs got IRW=%h PC4W=%h AOW=%h DRW=%h AdEL=%b AdES=%b want all 0",
               IRW, PC4W, AOW, DRW, AdELW, AdESW);
    else pass_cnt++;
    IRM = 32'h0;
    #1 Reset = 1'b1;
    issue(OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_word_byte();
    issue(OP_SW,  32'h10, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(OP_LW,  32'h10, 32'h0, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0);
    issue(OP_LBU, 32'h13, 32'h0, 1'b0, 32'h0, 32'h00000012, 1'b0, 1'b0);
    issue(OP_LB,  32'h10, 32'h0, 1'b0, 32'h0, 32'h00000078, 1'b0, 1'b0);
    issue(OP_LHU, 32'h12, 32'h0, 1'b0, 32'h0, 32'h00001234, 1'b0, 1'b0);
  endtask

  task automatic test_byte_store();
    issue(OP_SB, 32'h21, 32'h000000F0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(OP_LB, 32'h21, 32'h0, 1'b0, 32'h0, 32'hFFFFFFF0, 1'b0, 1'b0);
    issue(OP_LW, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0000F000, 1'b0, 1'b0);
    issue(OP_LBU, 32'h21, 32'h0, 1'b0, 32'h0, 32'h000000F0, 1'b0, 1'b0);
  endtask

  task automatic test_half();
    issue(OP_SH,  32'h32, 32'h00008001, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(OP_LH,  32'h32, 32'h0, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
    issue(OP_LHU, 32'h32, 32'h0, 1'b0, 32'h0, 32'h00008001, 1'b0, 1'b0);
    issue(OP_LW,  32'h30, 32'h0, 1'b0, 32'h0, 32'h80010000, 1'b0, 1'b0);
  endtask

  task automatic test_misaligned();
    issue(OP_SW,  32'h40, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(OP_SW,  32'h41, 32'h11111111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    issue(OP_LW,  32'h40, 32'h0, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
    issue(OP_LH,  32'h43, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    issue(OP_SH,  32'h43, 32'h22222222, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    issue(OP_LHU, 32'h41, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    issue(OP_LW,  32'h42, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    issue(OP_LW,  32'h40, 32'h0, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
  endtask

  task automatic test_forward();
    issue(OP_SW, 32'h1004, 32'h0, 1'b1, 32'hCAFEBABE, 32'h0, 1'b0, 1'b0);
    total_cnt++;
    if (AO !== 32'h1004) $display("FAIL ao_copy got %h want %h", AO, 32'h1004);
    else pass_cnt++;
    issue(OP_LW, 32'h0004, 32'h0, 1'b0, 32'h0, 32'hCAFEBABE, 1'b0, 1'b0);
    issue(OP_SW, 32'h8, 32'h0BADF00D, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    issue(OP_LW, 32'hFFFF_F008, 32'h0, 1'b0, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
  endtask

  task automatic test_nonmem();
    issue(6'b0,    32'h10, 32'h99999999, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(OP_ADDI, 32'h10, 32'h99999999, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(6'b101010, 32'h11, 32'h99999999, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(6'b100010, 32'h11, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(OP_LW,   32'h10, 32'h0, 1'b0, 32'h0, 32'h12345678, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    issue(OP_SW, 32'h50, 32'h55AA55AA, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(OP_LW, 32'h50, 32'h0, 1'b0, 32'h0, 32'h55AA55AA, 1'b0, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    #1 Reset = 1'b0;
    #1;
    total_cnt++;
    if ({IRW, PC4W, AOW, DRW, AdELW, AdESW} !== 130'h0)
      $display("FAIL reset_async got IRW=%h PC4W=%h AOW=%h DRW=%h AdEL=%b AdES=%b want all 0",
               IRW, PC4W, AOW, DRW, AdELW, AdESW);
    else pass_cnt++;
    IRM = {OP_SW, 26'h0};
    AOM = 32'h60;
    RTM = 32'h77777777;
    @(posedge Clk);
    #1;
    total_cnt++;
    if ({IRW, DRW, AdESW} !== 65'h0)
      $display("FAIL reset_hold got IRW=%h DRW=%h AdES=%b want 0", IRW, DRW, AdESW);
    else pass_cnt++;
    IRM = 32'h0;
    @(posedge Clk);
    #2 Reset = 1'b1;
    issue(OP_LW, 32'h50, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(OP_LW, 32'h60, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [10];
    logic [5:0]  op;
    logic [31:0] ao, rt, wd, sd, w, edrw;
    logic [7:0]  b;
    logic [15:0] h;
    logic        fwd, adel, ades;
    ops = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH, 6'b0, OP_ADDI};
    for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 9)];
      ao = ($urandom() & 32'hFFFF_F000) | (32'h200 + 32'($urandom_range(0, 63)));
      rt = $urandom();
      wd = $urandom();
      fwd = 1'($urandom_range(0, 1));
      sd = fwd ? wd : rt;
      w = mdl[ao[11:2]];
      b = 8'(w >> (8 * ao[1:0]));
      h = ao[1] ? w[31:16] : w[15:0];
      edrw = 32'h0; adel = 1'b0; ades = 1'b0;
      case (op)
        OP_LW:  begin adel = (ao[1:0] != 0); edrw = adel ? 32'h0 : w; end
        OP_LB:  edrw = {{24{b[7]}}, b};
        OP_LBU: edrw = {24'h0, b};
        OP_LH:  begin adel = ao[0]; edrw = adel ? 32'h0 : {{16{h[15]}}, h}; end
        OP_LHU: begin adel = ao[0]; edrw = adel ? 32'h0 : {16'h0, h}; end
        OP_SW:  begin ades = (ao[1:0] != 0); if (!ades) mdl[ao[11:2]] = sd; end
        OP_SH:  begin
          ades = ao[0];
          if (!ades) begin
            if (ao[1]) mdl[ao[11:2]][31:16] = sd[15:0];
            else       mdl[ao[11:2]][15:0]  = sd[15:0];
          end
        end
        OP_SB:  mdl[ao[11:2]][8*ao[1:0] +: 8] = sd[7:0];
        default: ;
      endcase
      issue(op, ao, rt, fwd, wd, edrw, adel, ades);
    end
  endtask

  initial begin
    test_reset();
    test_word_byte();
    test_byte_store();
    test_half();
    test_misaligned();
    test_forward();
    test_nonmem();
    test_reset_mid();
    test_back_to_back();
    go_idle();
    @(posedge Clk);
    @(negedge Clk);
    #1;
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL drain got %0d pending want 0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
